cla_4b: RTL and testbench



---
 rtl/adder_pkg.sv | 4 +
 rtl/pfa.sv | 13 +
 rtl/cla_4b.sv | 67 ++++++
 tb/tb_cla_4b.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants for the carry-lookahead adder family.
package adder_pkg;
    localparam int BW_DATA = 4;
endpackage

// File: rtl/pfa.sv
// Partial full adder: per-bit generate/propagate plus the sum once the carry is known.
module pfa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic g,
    output logic p,
    output logic s
);
    assign g = a & b;
    assign p = a ^ b;
    assign s = p ^ c;
endmodule

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder with group generate/propagate and a registered result.
module cla_4b
    import adder_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [BW_DATA-1:0] i_a,
    input  logic [BW_DATA-1:0] i_b,
    input  logic               i_c,
    output logic [BW_DATA-1:0] o_s,
    output logic               o_c,
    output logic               o_gg,
    output logic               o_gp,
    output logic [BW_DATA-1:0] o_s_q,
    output logic               o_c_q
);
    logic [BW_DATA-1:0] g;
    logic [BW_DATA-1:0] p;
    logic [BW_DATA-1:0] s;
    logic [BW_DATA:0]   c;
    logic [BW_DATA-1:0] s_d;
    logic [BW_DATA-1:0] s_q;
    logic               c_d;
    logic               c_q;

    for (genvar k = 0; k < BW_DATA; k++) begin : g_bit
        pfa u_pfa (
            .a (i_a[k]),
            .b (i_b[k]),
            .c (c[k]),
            .g (g[k]),
            .p (p[k]),
            .s (s[k])
        );
    end

    // Every carry is a flat sum of products on g/p and the carry-in, never on another carry.
    assign c[0] = i_c;
    assign c[1] = g[0] | (p[0] & i_c);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & i_c);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & i_c);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & i_c);

    assign o_gp = &p;
    assign o_gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign o_s  = s;
    assign o_c  = c[BW_DATA];

    always_comb begin
        s_d = s;
        c_d = c[BW_DATA];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_q <= '0;
            c_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
        end
    end

    assign o_s_q = s_q;
    assign o_c_q = c_q;
endmodule

// File: tb/tb_cla_4b.sv
// Self-checking bench for cla_4b: directed vectors, exhaustive sweep, registered-path model.
module tb_cla_4b;
    logic       i_clk;
    logic       i_rst;
    logic [3:0] i_a;
    logic [3:0] i_b;
    logic       i_c;
    logic [3:0] o_s;
    logic       o_c;
    logic       o_gg;
    logic       o_gp;
    logic [3:0] o_s_q;
    logic       o_c_q;

    int n_checks = 0;
    int n_fail   = 0;

    cla_4b dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_a   (i_a),
        .i_b   (i_b),
        .i_c   (i_c),
        .o_s   (o_s),
        .o_c   (o_c),
        .o_gg  (o_gg),
        .o_gp  (o_gp),
        .o_s_q (o_s_q),
        .o_c_q (o_c_q)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered-path model: what the register must hold after each edge.
    logic [4:0] exp_q;
    bit         model_valid = 1'b0;

    always @(posedge i_clk) begin
        if (i_rst) exp_q = 5'd0;
        else       exp_q = 5'(i_a) + 5'(i_b) + 5'(i_c);
        model_valid = 1'b1;
        #1;
        check("reg_sum", {3'b0, o_c_q, o_s_q}, {3'b0, exp_q});
    end

    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic c);
        @(negedge i_clk);
        i_a = a;
        i_b = b;
        i_c = c;
        #1;
    endtask

    // Group terms computed from their meaning: gp = every bit propagates,
    // gg = a carry leaves the group even with carry-in 0.
    function automatic logic model_gp(input logic [3:0] a, input logic [3:0] b);
        return (a ^ b) == 4'hF;
    endfunction
    function automatic logic model_gg(input logic [3:0] a, input logic [3:0] b);
        return (5'(a) + 5'(b)) > 5'd15;
    endfunction

    initial begin
        i_rst = 1'b1;
        i_a   = 4'h0;
        i_b   = 4'h0;
        i_c   = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_s_q", {4'b0, o_s_q}, 8'h00);
        check("rst_c_q", {7'b0, o_c_q}, 8'h00);

        apply(4'h0, 4'h0, 1'b1);
        check("cin_s",  {4'b0, o_s},  8'h01);
        check("cin_c",  {7'b0, o_c},  8'h00);
        check("cin_gg", {7'b0, o_gg}, 8'h00);
        check("cin_gp", {7'b0, o_gp}, 8'h00);

        apply(4'hF, 4'h1, 1'b0);
        check("chain_s",  {4'b0, o_s},  8'h00);
        check("chain_c",  {7'b0, o_c},  8'h01);
        check("chain_gg", {7'b0, o_gg}, 8'h01);

        apply(4'h5, 4'hA, 1'b0);
        check("prop0_s",  {4'b0, o_s},  8'h0F);
        check("prop0_c",  {7'b0, o_c},  8'h00);
        check("prop0_gp", {7'b0, o_gp}, 8'h01);

        apply(4'h5, 4'hA, 1'b1);
        check("prop1_s", {4'b0, o_s}, 8'h00);
        check("prop1_c", {7'b0, o_c}, 8'h01);

        apply(4'hF, 4'hF, 1'b1);
        check("max_s",  {4'b0, o_s},  8'h0F);
        check("max_c",  {7'b0, o_c},  8'h01);
        check("max_gp", {7'b0, o_gp}, 8'h00);

        // Reset does not touch the combinational path.
        check("rst_comb", {3'b0, o_c, o_s}, 8'h1F);

        // Release reset with 9 + 8 + 0 on the inputs.
        @(negedge i_clk);
        i_rst = 1'b0;
        i_a   = 4'h9;
        i_b   = 4'h8;
        i_c   = 1'b0;
        @(posedge i_clk);
        #1;
        check("rel_s_q", {4'b0, o_s_q}, 8'h01);
        check("rel_c_q", {7'b0, o_c_q}, 8'h01);

        for (int v = 0; v < 512; v++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            a = v[8:5];
            b = v[4:1];
            c = v[0];
            apply(a, b, c);
            check("exh_sum", {3'b0, o_c, o_s}, {3'b0, 5'(a) + 5'(b) + 5'(c)});
            check("exh_cons", {7'b0, o_c}, {7'b0, o_gg | (o_gp & c)});
            check("exh_gp", {7'b0, o_gp}, {7'b0, model_gp(a, b)});
            check("exh_gg", {7'b0, o_gg}, {7'b0, model_gg(a, b)});
        end

        // Mid-stream reset, then resume.
        @(negedge i_clk);
        i_rst = 1'b1;
        i_a   = 4'h3;
        i_b   = 4'h4;
        i_c   = 1'b0;
        @(posedge i_clk);
        #1;
        check("mid_rst_s_q", {4'b0, o_s_q}, 8'h00);
        check("mid_rst_c_q", {7'b0, o_c_q}, 8'h00);
        check("mid_rst_comb", {4'b0, o_s}, 8'h07);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("resume_s_q", {4'b0, o_s_q}, 8'h07);
        check("resume_c_q", {7'b0, o_c_q}, 8'h00);

        @(negedge i_clk);
        if (!model_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_valid: got 0, expected 1");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
